// File: rtl/pc_gen_predictor.sv
// Fetch-stage next-PC generator with a bimodal 2-bit BHT and a tagged BTB,
// trained and redirected by branch resolution from the execute stage.
module pc_gen_predictor #(
  parameter int              PC_W    = 32,
  parameter int              IDX_W   = 4,
  parameter logic [PC_W-1:0] INIT_PC = '0,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             resolve_valid,
  input  logic             resolve_is_branch,
  input  logic [PC_W-1:0]  resolve_pc,
  input  logic             resolve_taken,
  input  logic [PC_W-1:0]  resolve_target,
  input  logic             resolve_mispredict,
  input  logic [PC_W-1:0]  resolve_next_pc,
  output logic [PC_W-1:0]  PC,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int               DEPTH   = 2 ** IDX_W;
  localparam int               TAG_W   = PC_W - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       bht        [DEPTH];
  logic [DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [DEPTH];
  logic [PC_W-1:0]  btb_target [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [IDX_W-1:0] r_idx;
  logic             redirect;
  logic             train;

  // Lookup reads the registered tables, so a same-cycle write is seen next cycle.
  assign idx         = PC[IDX_W-1:0];
  assign tag         = PC[PC_W-1:IDX_W];
  assign hit         = btb_valid[idx] && (btb_tag[idx] == tag);
  assign pred_taken  = hit && bht[idx][1];
  assign pred_target = pred_taken ? btb_target[idx] : PC + PC_W'(1);

  assign r_idx    = resolve_pc[IDX_W-1:0];
  assign redirect = resolve_valid && resolve_mispredict;
  assign train    = resolve_valid && resolve_is_branch;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC               <= INIT_PC;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (redirect)   PC <= resolve_next_pc;
      else if (!stall) PC <= pred_target;

      if (train && branch_count != CNT_MAX)
        branch_count <= branch_count + CNT_W'(1);
      if (redirect && mispredict_count != CNT_MAX)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
      btb_valid <= '0;
    end else if (train) begin
      if (resolve_taken) begin
        if (bht[r_idx] != 2'b11) bht[r_idx] <= bht[r_idx] + 2'd1;
        btb_valid[r_idx] <= 1'b1;
      end else if (bht[r_idx] != 2'b00) begin
        bht[r_idx] <= bht[r_idx] - 2'd1;
      end
    end
  end

  // NOTE: tag/target storage is deliberately not reset; the valid bits
  // gate every use, so the payload may hold stale data after reset.
  always_ff @(posedge clk) begin
    if (!reset && train && resolve_taken) begin
      btb_tag[r_idx]    <= resolve_pc[PC_W-1:IDX_W];
      btb_target[r_idx] <= resolve_target;
    end
  end

endmodule
